contador_de_pontos: RTL and testbench
=====================================

# contador_de_pontos

Score keeper for the rhythm game, and the receiving end of the per-lane hit/miss pulses the `pattern` lanes emit. Detects rising edges on each lane's `ponto`/`erro` lines and maintains the combo and the multiplier. Accumulates a saturating decimal score held directly in BCD, and drives the 20-bit `display` word consumed by `placar` for the HEX digits. It replaces the ad-hoc `posedge ponto` counter with a single-clock, edge-detected design.

## Interface
Parameters:
- `LANES`, 3, number of pattern lanes feeding events
- `DIGITS`, 5, BCD digits of score (display width = 4*DIGITS)
- `COMBO_STEP`, 10, consecutive hits per multiplier increment
- `MAX_MULT`, 4, multiplier ceiling

Ports:
- `CLOCK_25`  in  1  system clock; the pattern lanes run on the same clock
- `reset_n`  in  1  asynchronous, active-low reset
- `ponto`  in  LANES  per-lane hit level; each rising edge is one hit
- `erro`  in  LANES  per-lane miss level; each rising edge is one miss
- `clear`  in  1  synchronous new-game clear
- `fim_de_jogo`  in  1  freeze; while high, all edges are ignored and not queued
- `display`  out  4*DIGITS  BCD score, digit 0 (units) in [3:0]
- `combo`  out  8  consecutive-hit count, binary, saturates at 255
- `max_combo`  out  8  highest `combo` value since reset/clear
- `multiplier`  out  3  current points per hit, 1..MAX_MULT
- `evento`  out  1  one-cycle pulse on any cycle with an accepted hit or miss

## Operation
- Edge detection:
  - `ponto_q`/`erro_q` register the inputs every cycle, including while frozen, so no stale edge fires after unfreeze.
  - `hit = ponto & ~ponto_q`, `miss = erro & ~erro_q`, both masked by `~fim_de_jogo`.
- Per cycle:
  - `n_hit` = popcount(hit), 0..LANES.
  - `any_miss` = |miss.
- Score update:
  - `add = n_hit * multiplier`, using the multiplier before this cycle's update; max 12.
  - `display` ← `display` + `add`, as a BCD add.
  - The score saturates at all-nines (99999) and never wraps.
- Combo update:
  - If `any_miss`: `combo` ← 0, `step` ← 0, `multiplier` ← 1. This happens even when hits arrive in the same cycle; those hits still score before the reset.
  - Else `combo` ← min(`combo` + `n_hit`, 255). The internal `step` counter (0..COMBO_STEP−1) adds `n_hit`.
  - If `step` ≥ COMBO_STEP: `step` ← `step` − COMBO_STEP and `multiplier` ← min(`multiplier` + 1, MAX_MULT).
- `max_combo` ← max(`max_combo`, next `combo`).
- `evento` = registered (`n_hit` ≠ 0 | `any_miss`).
- Priority: `reset_n` > `clear` > `fim_de_jogo` > events.
  - `clear` zeroes score, combo, step and max_combo, and sets multiplier to 1.
  - Edges on the same cycle as `clear` are discarded.
  - Edge registers still sample on `clear` cycles.

## Timing
- Reset values (asynchronous, immediate on `reset_n`=0):
  - `display`=0, `combo`=0, `max_combo`=0, `multiplier`=1, `evento`=0.
  - `ponto_q`/`erro_q`=0. An input already high at reset release therefore counts as an edge on the first clock.
- Latency: an input first sampled high at clock edge k is reflected in all outputs after edge k (one register stage). There is no pipelining beyond that.
- Minimum event spacing per lane: 2 cycles (high then low) per hit. Levels held high produce exactly one event.
- Reset asserted mid-update: outputs return to reset values at once, and no partial BCD state remains.
- The BCD add is combinational across all DIGITS and must close at 25 MHz.

## Structure
- Package `pontos_pkg`:
  - constants `COMBO_MAX`=255, `BCD_NINE`=4'd9.
  - function `popcount3`.
  - the mult/step width localparams.
- Sub-module `bcd_somador`:
  - adds a 4-bit binary value (0..15) to a DIGITS-wide BCD word.
  - converts the value to tens/units internally, ripple carries across digits, and saturates to all-nines.
- Top of block: edge registers, combo/step/mult/max FSM-free datapath, and the `evento` register.

## Test plan
- Reset, then a single edge on `ponto[0]` → `display`=0x00001, `combo`=1, `multiplier`=1, and `evento` high for exactly one cycle.
- 10 sequential single-lane hits, then 1 more → after the 10th, `multiplier`=2; after the 11th, `display`=0x00012 and `combo`=11.
- Simultaneous edges on all 3 lanes with `multiplier`=4 (combo ≥30) → `display` increases by 12 in BCD in one cycle, e.g. 0x00095 → 0x00107.
- Hit on lane 1 and miss on lane 2 in the same cycle with `multiplier`=3 → score +3, `combo`=0, `multiplier`=1, `max_combo` unchanged from its prior peak.
- Preload 99995 via hits, then 3-lane hit at multiplier 4 → `display`=0x99999, with no wrap.
- `ponto[0]` held high across a `fim_de_jogo` pulse, then `fim_de_jogo` drops → no event. A `clear` pulse → all outputs equal their reset values on the next cycle.

Source files
------------

// File: rtl/contador_de_pontos_pkg.sv
// Shared widths, constants and helpers for the rhythm-game score keeper.
package pontos_pkg;

    localparam int MULT_W = 3;
    localparam int STEP_W = 4;
    localparam int NHIT_W = 2;
    localparam int ADD_W  = 4;

    localparam logic [7:0] COMBO_MAX = 8'd255;
    localparam logic [3:0] BCD_NINE  = 4'd9;

    function automatic logic [NHIT_W-1:0] popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/contador_de_pontos_bcd_somador.sv
// Adds a 0..15 binary value to a packed BCD word, saturating at all-nines.
module bcd_somador
    import pontos_pkg::*;
#(
    parameter int DIGITS = 5
) (
    input  logic [4*DIGITS-1:0] bcd_in,
    input  logic [ADD_W-1:0]    valor,
    output logic [4*DIGITS-1:0] bcd_out
);

    logic [3:0]          units_s;
    logic [3:0]          tens_s;
    logic [3:0]          addend_s;
    logic [4:0]          digit_sum_s;
    logic [4:0]          digit_adj_s;
    logic                carry_s;
    logic [4*DIGITS-1:0] soma_s;

    // Split the addend into tens/units, ripple a decimal carry through every digit
    always_comb begin
        units_s     = 4'd0;
        tens_s      = 4'd0;
        addend_s    = 4'd0;
        digit_sum_s = 5'd0;
        digit_adj_s = 5'd0;
        carry_s     = 1'b0;
        soma_s      = '0;
        bcd_out     = '0;

        if (valor >= 4'd10) begin
            tens_s  = 4'd1;
            units_s = valor - 4'd10;
        end else begin
            tens_s  = 4'd0;
            units_s = valor;
        end

        for (int i = 0; i < DIGITS; i++) begin
            if (i == 0) begin
                addend_s = units_s;
            end else if (i == 1) begin
                addend_s = tens_s;
            end else begin
                addend_s = 4'd0;
            end
            digit_sum_s = {1'b0, bcd_in[4*i +: 4]} + {1'b0, addend_s} + {4'd0, carry_s};
            digit_adj_s = digit_sum_s - 5'd10;
            if (digit_sum_s > {1'b0, BCD_NINE}) begin
                soma_s[4*i +: 4] = digit_adj_s[3:0];
                carry_s          = 1'b1;
            end else begin
                soma_s[4*i +: 4] = digit_sum_s[3:0];
                carry_s          = 1'b0;
            end
        end

        // A carry out of the top digit means the score would wrap
        if (carry_s) begin
            bcd_out = {DIGITS{BCD_NINE}};
        end else begin
            bcd_out = soma_s;
        end
    end

endmodule

// File: rtl/contador_de_pontos.sv
// Score keeper: edge-detects per-lane hit/miss levels, tracks combo and multiplier, keeps a BCD score.
module contador_de_pontos
    import pontos_pkg::*;
#(
    parameter int LANES      = 3,
    parameter int DIGITS     = 5,
    parameter int COMBO_STEP = 10,
    parameter int MAX_MULT   = 4
) (
    input  logic                CLOCK_25,
    input  logic                reset_n,
    input  logic [LANES-1:0]    ponto,
    input  logic [LANES-1:0]    erro,
    input  logic                clear,
    input  logic                fim_de_jogo,
    output logic [4*DIGITS-1:0] display,
    output logic [7:0]          combo,
    output logic [7:0]          max_combo,
    output logic [MULT_W-1:0]   multiplier,
    output logic                evento
);

    localparam logic [STEP_W-1:0] COMBO_STEP_C = STEP_W'(COMBO_STEP);
    localparam logic [MULT_W-1:0] MAX_MULT_C   = MULT_W'(MAX_MULT);
    localparam logic [MULT_W-1:0] MULT_ONE     = MULT_W'(1);

    logic [LANES-1:0]           ponto_q_r;
    logic [LANES-1:0]           erro_q_r;
    logic [STEP_W-1:0]          step_r;

    logic [LANES-1:0]           hit_s;
    logic [LANES-1:0]           miss_s;
    logic [NHIT_W-1:0]          n_hit_s;
    logic                       any_miss_s;
    logic [NHIT_W+MULT_W-1:0]   produto_s;
    logic [ADD_W-1:0]           add_s;
    logic [4*DIGITS-1:0]        soma_s;
    logic [8:0]                 combo_sum_s;
    logic [7:0]                 combo_next_s;
    logic [STEP_W-1:0]          step_sum_s;
    logic [STEP_W-1:0]          step_next_s;
    logic [MULT_W-1:0]          mult_next_s;
    logic [7:0]                 max_next_s;

    // Edge detection, per-cycle event summary and next combo/step/multiplier
    always_comb begin
        hit_s        = ponto & ~ponto_q_r & {LANES{~fim_de_jogo}};
        miss_s       = erro & ~erro_q_r & {LANES{~fim_de_jogo}};
        n_hit_s      = popcount3(hit_s);
        any_miss_s   = |miss_s;
        produto_s    = {{MULT_W{1'b0}}, n_hit_s} * {{NHIT_W{1'b0}}, multiplier};
        add_s        = produto_s[ADD_W-1:0];
        combo_sum_s  = {1'b0, combo} + {7'd0, n_hit_s};
        step_sum_s   = step_r + {{(STEP_W-NHIT_W){1'b0}}, n_hit_s};
        combo_next_s = combo;
        step_next_s  = step_r;
        mult_next_s  = multiplier;

        // A miss resets the streak even if hits land on the same cycle
        if (any_miss_s) begin
            combo_next_s = 8'd0;
            step_next_s  = '0;
            mult_next_s  = MULT_ONE;
        end else begin
            if (combo_sum_s > {1'b0, COMBO_MAX}) begin
                combo_next_s = COMBO_MAX;
            end else begin
                combo_next_s = combo_sum_s[7:0];
            end
            if (step_sum_s >= COMBO_STEP_C) begin
                step_next_s = step_sum_s - COMBO_STEP_C;
                if (multiplier < MAX_MULT_C) begin
                    mult_next_s = multiplier + MULT_ONE;
                end else begin
                    mult_next_s = MAX_MULT_C;
                end
            end else begin
                step_next_s = step_sum_s;
                mult_next_s = multiplier;
            end
        end

        if (combo_next_s > max_combo) begin
            max_next_s = combo_next_s;
        end else begin
            max_next_s = max_combo;
        end
    end

    bcd_somador #(
        .DIGITS (DIGITS)
    ) u_bcd_somador (
        .bcd_in  (display),
        .valor   (add_s),
        .bcd_out (soma_s)
    );

    // State registers; edge history keeps sampling through clear and freeze
    always_ff @(posedge CLOCK_25 or negedge reset_n) begin
        if (!reset_n) begin
            ponto_q_r  <= '0;
            erro_q_r   <= '0;
            display    <= '0;
            combo      <= 8'd0;
            max_combo  <= 8'd0;
            step_r     <= '0;
            multiplier <= MULT_ONE;
            evento     <= 1'b0;
        end else begin
            ponto_q_r <= ponto;
            erro_q_r  <= erro;
            if (clear) begin
                display    <= '0;
                combo      <= 8'd0;
                max_combo  <= 8'd0;
                step_r     <= '0;
                multiplier <= MULT_ONE;
                evento     <= 1'b0;
            end else begin
                display    <= soma_s;
                combo      <= combo_next_s;
                max_combo  <= max_next_s;
                step_r     <= step_next_s;
                multiplier <= mult_next_s;
                evento     <= (n_hit_s != '0) | any_miss_s;
            end
        end
    end

endmodule

// File: tb/tb_contador_de_pontos.sv
// Directed self-checking bench for contador_de_pontos.
module tb_contador_de_pontos;

    logic        clk;
    logic        reset_n;
    logic [2:0]  ponto;
    logic [2:0]  erro;
    logic        clear;
    logic        fim_de_jogo;
    logic [19:0] display;
    logic [7:0]  combo;
    logic [7:0]  max_combo;
    logic [2:0]  multiplier;
    logic        evento;

    int checks = 0;
    int errors = 0;

    contador_de_pontos dut (
        .CLOCK_25    (clk),
        .reset_n     (reset_n),
        .ponto       (ponto),
        .erro        (erro),
        .clear       (clear),
        .fim_de_jogo (fim_de_jogo),
        .display     (display),
        .combo       (combo),
        .max_combo   (max_combo),
        .multiplier  (multiplier),
        .evento      (evento)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // One hit/miss pulse: levels high for one cycle, then low; returns just after the update
    task automatic pulse(input logic [2:0] p, input logic [2:0] e);
        @(negedge clk);
        ponto = p;
        erro  = e;
        @(negedge clk);
        ponto = 3'b000;
        erro  = 3'b000;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; ponto = 3'b000; erro = 3'b000; clear = 1'b0; fim_de_jogo = 1'b0;
        repeat (3) @(negedge clk);
        checks = checks + 1;
        if (display !== 20'h00000) begin errors = errors + 1; $display("FAIL reset_display: got %h want %h", display, 20'h00000); end
        checks = checks + 1;
        if (combo !== 8'd0 || max_combo !== 8'd0) begin errors = errors + 1; $display("FAIL reset_combo: got %0d/%0d want 0/0", combo, max_combo); end
        checks = checks + 1;
        if (multiplier !== 3'd1 || evento !== 1'b0) begin errors = errors + 1; $display("FAIL reset_mult_evento: got %0d/%b want 1/0", multiplier, evento); end
        reset_n = 1'b1;
    endtask

    task automatic test_single_hit;
        pulse(3'b001, 3'b000);
        checks = checks + 1;
        if (display !== 20'h00001) begin errors = errors + 1; $display("FAIL single_display: got %h want %h", display, 20'h00001); end
        checks = checks + 1;
        if (combo !== 8'd1 || multiplier !== 3'd1) begin errors = errors + 1; $display("FAIL single_combo_mult: got %0d/%0d want 1/1", combo, multiplier); end
        checks = checks + 1;
        if (evento !== 1'b1) begin errors = errors + 1; $display("FAIL single_evento_high: got %b want 1", evento); end
        @(negedge clk);
        checks = checks + 1;
        if (evento !== 1'b0) begin errors = errors + 1; $display("FAIL single_evento_low: got %b want 0", evento); end
    endtask

    task automatic test_clear;
        @(negedge clk);
        clear = 1'b1; ponto = 3'b001;
        @(negedge clk);
        checks = checks + 1;
        if (display !== 20'h00000 || combo !== 8'd0 || max_combo !== 8'd0) begin
            errors = errors + 1; $display("FAIL clear_values: got %h/%0d/%0d want 0/0/0", display, combo, max_combo);
        end
        checks = checks + 1;
        if (multiplier !== 3'd1 || evento !== 1'b0) begin errors = errors + 1; $display("FAIL clear_mult_evento: got %0d/%b want 1/0", multiplier, evento); end
        clear = 1'b0;
        @(negedge clk);
        checks = checks + 1;
        if (evento !== 1'b0 || display !== 20'h00000) begin errors = errors + 1; $display("FAIL clear_edge_discarded: got %b/%h want 0/0", evento, display); end
        ponto = 3'b000;
    endtask

    task automatic test_multiplier;
        for (int i = 0; i < 10; i++) pulse(3'b001, 3'b000);
        checks = checks + 1;
        if (multiplier !== 3'd2 || display !== 20'h00010) begin errors = errors + 1; $display("FAIL mult_after_10: got %0d/%h want 2/%h", multiplier, display, 20'h00010); end
        pulse(3'b001, 3'b000);
        checks = checks + 1;
        if (display !== 20'h00012 || combo !== 8'd11) begin errors = errors + 1; $display("FAIL mult_after_11: got %h/%0d want %h/11", display, combo, 20'h00012); end
    endtask

    task automatic test_three_lanes;
        for (int i = 0; i < 19; i++) pulse(3'b001, 3'b000);
        checks = checks + 1;
        if (display !== 20'h00060 || multiplier !== 3'd4 || combo !== 8'd30) begin
            errors = errors + 1; $display("FAIL three_preload: got %h/%0d/%0d want %h/4/30", display, multiplier, combo, 20'h00060);
        end
        pulse(3'b111, 3'b000);
        checks = checks + 1;
        if (display !== 20'h00072) begin errors = errors + 1; $display("FAIL three_first: got %h want %h", display, 20'h00072); end
        pulse(3'b111, 3'b000);
        pulse(3'b111, 3'b000);
        checks = checks + 1;
        if (display !== 20'h00096) begin errors = errors + 1; $display("FAIL three_third: got %h want %h", display, 20'h00096); end
        pulse(3'b111, 3'b000);
        checks = checks + 1;
        if (display !== 20'h00108 || combo !== 8'd42 || multiplier !== 3'd4 || max_combo !== 8'd42) begin
            errors = errors + 1; $display("FAIL three_carry: got %h/%0d/%0d/%0d want %h/42/4/42", display, combo, multiplier, max_combo, 20'h00108);
        end
    endtask

    task automatic test_hit_and_miss;
        pulse(3'b000, 3'b001);
        checks = checks + 1;
        if (combo !== 8'd0 || multiplier !== 3'd1 || display !== 20'h00108 || evento !== 1'b1) begin
            errors = errors + 1; $display("FAIL miss_only: got %0d/%0d/%h/%b want 0/1/%h/1", combo, multiplier, display, evento, 20'h00108);
        end
        for (int i = 0; i < 20; i++) pulse(3'b001, 3'b000);
        checks = checks + 1;
        if (multiplier !== 3'd3 || display !== 20'h00138) begin errors = errors + 1; $display("FAIL miss_rebuild: got %0d/%h want 3/%h", multiplier, display, 20'h00138); end
        pulse(3'b010, 3'b100);
        checks = checks + 1;
        if (display !== 20'h00141) begin errors = errors + 1; $display("FAIL hit_miss_score: got %h want %h", display, 20'h00141); end
        checks = checks + 1;
        if (combo !== 8'd0 || multiplier !== 3'd1 || max_combo !== 8'd42) begin
            errors = errors + 1; $display("FAIL hit_miss_combo: got %0d/%0d/%0d want 0/1/42", combo, multiplier, max_combo);
        end
    endtask

    task automatic test_saturation;
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        for (int i = 0; i < 3; i++) pulse(3'b001, 3'b000);
        pulse(3'b000, 3'b010);
        for (int i = 0; i < 30; i++) pulse(3'b001, 3'b000);
        checks = checks + 1;
        if (display !== 20'h00063 || multiplier !== 3'd4) begin errors = errors + 1; $display("FAIL sat_stage: got %h/%0d want %h/4", display, multiplier, 20'h00063); end
        for (int i = 0; i < 8327; i++) pulse(3'b111, 3'b000);
        pulse(3'b011, 3'b000);
        checks = checks + 1;
        if (display !== 20'h99995) begin errors = errors + 1; $display("FAIL sat_preload: got %h want %h", display, 20'h99995); end
        checks = checks + 1;
        if (combo !== 8'd255 || max_combo !== 8'd255) begin errors = errors + 1; $display("FAIL sat_combo: got %0d/%0d want 255/255", combo, max_combo); end
        pulse(3'b111, 3'b000);
        checks = checks + 1;
        if (display !== 20'h99999) begin errors = errors + 1; $display("FAIL sat_clamp: got %h want %h", display, 20'h99999); end
        pulse(3'b111, 3'b000);
        checks = checks + 1;
        if (display !== 20'h99999) begin errors = errors + 1; $display("FAIL sat_hold: got %h want %h", display, 20'h99999); end
    endtask

    task automatic test_freeze;
        @(negedge clk); fim_de_jogo = 1'b1;
        @(negedge clk); ponto = 3'b001; erro = 3'b100;
        @(negedge clk);
        checks = checks + 1;
        if (evento !== 1'b0 || combo !== 8'd255) begin errors = errors + 1; $display("FAIL freeze_masked: got %b/%0d want 0/255", evento, combo); end
        fim_de_jogo = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks = checks + 1;
            if (evento !== 1'b0 || combo !== 8'd255 || multiplier !== 3'd4) begin
                errors = errors + 1; $display("FAIL freeze_no_stale: got %b/%0d/%0d want 0/255/4", evento, combo, multiplier);
            end
        end
        ponto = 3'b000; erro = 3'b000;
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        checks = checks + 1;
        if (display !== 20'h00000 || combo !== 8'd0 || max_combo !== 8'd0 || multiplier !== 3'd1 || evento !== 1'b0) begin
            errors = errors + 1; $display("FAIL freeze_clear: got %h/%0d/%0d/%0d/%b want 0/0/0/1/0", display, combo, max_combo, multiplier, evento);
        end
    endtask

    task automatic test_reset_mid;
        pulse(3'b111, 3'b000);
        #5 reset_n = 1'b0;
        #1;
        checks = checks + 1;
        if (display !== 20'h00000 || combo !== 8'd0 || evento !== 1'b0 || multiplier !== 3'd1) begin
            errors = errors + 1; $display("FAIL reset_async: got %h/%0d/%b/%0d want 0/0/0/1", display, combo, evento, multiplier);
        end
        ponto = 3'b001;
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
        checks = checks + 1;
        if (display !== 20'h00001 || combo !== 8'd1 || evento !== 1'b1) begin
            errors = errors + 1; $display("FAIL reset_release_edge: got %h/%0d/%b want %h/1/1", display, combo, evento, 20'h00001);
        end
        ponto = 3'b000;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_clear();
        test_multiplier();
        test_three_lanes();
        test_hit_and_miss();
        test_saturation();
        test_freeze();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
